// File: rtl/proc_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | proc_cmd_pkg : opcodes, instruction-word layout, issuer states   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package proc_cmd_pkg;

   localparam int c_op_w = 3;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_LOAD  = 3'd4;
   localparam logic [2:0] OP_STORE = 3'd5;
   localparam logic [2:0] OP_JUMP  = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_issue   = 3'd1;
   localparam logic [2:0] c_st_release = 3'd2;
   localparam logic [2:0] c_st_capture = 3'd3;
   localparam logic [2:0] c_st_finish  = 3'd4;

   // Word layout, MSB first: {opcode, addr, operand_a, operand_b}
   function automatic int f_word_w(input int aw, input int dw);
      return c_op_w + aw + 2 * dw;
   endfunction

   function automatic int f_a_lsb(input int dw);
      return dw;
   endfunction

   function automatic int f_addr_lsb(input int dw);
      return 2 * dw;
   endfunction

   function automatic int f_op_lsb(input int aw, input int dw);
      return 2 * dw + aw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/proc_cmd_prog_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | proc_cmd_prog_ram : program store, sync write / async read       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module proc_cmd_prog_ram #(
   parameter int DEPTH  = 16,
   parameter int WORD_W = 43
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic [WORD_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [WORD_W-1:0]        rd_data
);

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/proc_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | proc_cmd_issuer : runs a stored program through the host's       |
// | execute/ready handshake and checks the host PC each step         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module proc_cmd_issuer
   import proc_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int PROG_DEPTH = 16,
   parameter int TIMEOUT    = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  load_en,
   input  logic [$clog2(PROG_DEPTH)-1:0]         load_idx,
   input  logic [3+ADDR_WIDTH+2*DATA_WIDTH-1:0]  load_word,
   input  logic [$clog2(PROG_DEPTH):0]           prog_len,
   input  logic                                  start,
   input  logic                                  proc_ready,
   input  logic                                  proc_halt,
   input  logic [DATA_WIDTH-1:0]                 proc_result,
   input  logic [ADDR_WIDTH-1:0]                 proc_pc,
   output logic                                  execute,
   output logic [2:0]                            opcode,
   output logic [ADDR_WIDTH-1:0]                 addr,
   output logic [DATA_WIDTH-1:0]                 operand_a,
   output logic [DATA_WIDTH-1:0]                 operand_b,
   output logic                                  busy,
   output logic                                  done,
   output logic [DATA_WIDTH-1:0]                 last_result,
   output logic [$clog2(PROG_DEPTH):0]           issued_count,
   output logic                                  pc_mismatch,
   output logic                                  timeout_err
);

   localparam int c_idx_w  = $clog2(PROG_DEPTH);
   localparam int c_cnt_w  = c_idx_w + 1;
   localparam int c_word_w = f_word_w(ADDR_WIDTH, DATA_WIDTH);
   localparam int c_wait_w = $clog2(TIMEOUT + 1);

   logic [2:0]            r_state;
   logic [2:0]            w_state_next;
   logic [c_wait_w-1:0]   r_wait;
   logic [ADDR_WIDTH-1:0] r_pc_exp;
   logic [ADDR_WIDTH-1:0] w_pc_pred;
   logic [c_cnt_w-1:0]    w_issued_inc;
   logic [c_idx_w-1:0]    w_rd_idx;
   logic [c_word_w-1:0]   w_rd_word;
   logic                  w_tmo;
   logic                  w_run_end;
   logic                  w_clear;
   logic                  w_load_cmd;
   logic                  w_capture;
   logic                  w_set_tmo;

   proc_cmd_prog_ram #(
      .DEPTH  (PROG_DEPTH),
      .WORD_W (c_word_w)
   ) u_prog_ram (
      .clk     (clk),
      .wr_en   (load_en && !busy),
      .wr_idx  (load_idx),
      .wr_data (load_word),
      .rd_idx  (w_rd_idx),
      .rd_data (w_rd_word)
   );

   assign w_issued_inc = issued_count + c_cnt_w'(1);
   // Slot N+1 is fetched during the capture of slot N; a run always starts at 0.
   assign w_rd_idx     = (r_state == c_st_capture) ? w_issued_inc[c_idx_w-1:0] : '0;
   assign w_tmo        = (r_wait == c_wait_w'(TIMEOUT - 1));
   assign w_run_end    = (opcode == OP_HALT) || proc_halt || (w_issued_inc == prog_len);

   // Host PC after the instruction now on the bus; saturates instead of wrapping.
   always_comb begin
      w_pc_pred = r_pc_exp;
      case (opcode)
         OP_JUMP: w_pc_pred = addr;
         OP_HALT: w_pc_pred = r_pc_exp;
         default: if (r_pc_exp != '1) w_pc_pred = r_pc_exp + ADDR_WIDTH'(1);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) w_state_next = (prog_len == '0) ? c_st_finish : c_st_issue;
         end
         c_st_issue: begin
            if (!proc_ready) w_state_next = c_st_release;
            else if (w_tmo)  w_state_next = c_st_finish;
         end
         c_st_release: begin
            if (proc_ready) w_state_next = c_st_capture;
            else if (w_tmo) w_state_next = c_st_finish;
         end
         c_st_capture: w_state_next = w_run_end ? c_st_finish : c_st_issue;
         c_st_finish:  w_state_next = c_st_idle;
         default:      w_state_next = c_st_idle;
      endcase
   end

   always_comb begin
      w_clear    = 1'b0;
      w_load_cmd = 1'b0;
      w_capture  = 1'b0;
      w_set_tmo  = 1'b0;
      case (r_state)
         c_st_idle: begin
            w_clear    = start;
            w_load_cmd = start && (prog_len != '0);
         end
         c_st_issue, c_st_release: w_set_tmo = (w_state_next == c_st_finish);
         c_st_capture: begin
            w_capture  = 1'b1;
            w_load_cmd = !w_run_end;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         execute      <= 1'b0;
         opcode       <= '0;
         addr         <= '0;
         operand_a    <= '0;
         operand_b    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         last_result  <= '0;
         issued_count <= '0;
         pc_mismatch  <= 1'b0;
         timeout_err  <= 1'b0;
         r_pc_exp     <= '0;
         r_wait       <= '0;
      end else begin
         execute <= (w_state_next == c_st_issue);
         busy    <= (w_state_next == c_st_issue) || (w_state_next == c_st_release) ||
                    (w_state_next == c_st_capture);
         done    <= (w_state_next == c_st_finish);
         if (w_state_next != r_state) r_wait <= '0;
         else if (r_wait != '1)       r_wait <= r_wait + c_wait_w'(1);
         if (w_clear) begin
            issued_count <= '0;
            pc_mismatch  <= 1'b0;
            timeout_err  <= 1'b0;
         end
         if (w_load_cmd) begin
            opcode    <= w_rd_word[f_op_lsb(ADDR_WIDTH, DATA_WIDTH) +: 3];
            addr      <= w_rd_word[f_addr_lsb(DATA_WIDTH) +: ADDR_WIDTH];
            operand_a <= w_rd_word[f_a_lsb(DATA_WIDTH) +: DATA_WIDTH];
            operand_b <= w_rd_word[0 +: DATA_WIDTH];
         end
         if (w_capture) begin
            last_result  <= proc_result;
            issued_count <= w_issued_inc;
            r_pc_exp     <= w_pc_pred;
            if (proc_pc != w_pc_pred) pc_mismatch <= 1'b1;
         end
         if (w_set_tmo) timeout_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_proc_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_proc_cmd_issuer : issuer against a behavioural host, with a   |
// | result scoreboard filled at run start and drained per capture    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_proc_cmd_issuer;
   import proc_cmd_pkg::*;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int PD = 16;
   localparam int IW = 4;
   localparam int CW = 5;
   localparam int WW = 3 + AW + 2 * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b0;
   logic [IW-1:0] load_idx = '0;
   logic [WW-1:0] load_word = '0;
   logic [CW-1:0] prog_len = '0;
   logic          start = 1'b0;
   logic          proc_ready;
   logic          proc_halt;
   logic [DW-1:0] proc_result;
   logic [AW-1:0] proc_pc;
   logic          execute;
   logic [2:0]    opcode;
   logic [AW-1:0] addr;
   logic [DW-1:0] operand_a;
   logic [DW-1:0] operand_b;
   logic          busy;
   logic          done;
   logic [DW-1:0] last_result;
   logic [CW-1:0] issued_count;
   logic          pc_mismatch;
   logic          timeout_err;

   typedef struct {
      logic [DW-1:0] res;
      logic          mm;
   } exp_t;

   exp_t          sb[$];
   exp_t          e_mon;
   int            n_checks = 0;
   int            n_fail = 0;
   int            glitch_n = 0;
   int            h_cnt;
   logic [DW-1:0] h_acc;
   logic [DW-1:0] m_acc = '0;
   logic [DW-1:0] m_res = '0;
   logic [CW-1:0] prev_cnt = '0;
   logic [2:0]    p_op   [PD];
   logic [AW-1:0] p_addr [PD];
   logic [DW-1:0] p_a    [PD];
   logic [DW-1:0] p_b    [PD];

   always #5 clk = ~clk;

   proc_cmd_issuer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .PROG_DEPTH (PD),
      .TIMEOUT    (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en      (load_en),
      .load_idx     (load_idx),
      .load_word    (load_word),
      .prog_len     (prog_len),
      .start        (start),
      .proc_ready   (proc_ready),
      .proc_halt    (proc_halt),
      .proc_result  (proc_result),
      .proc_pc      (proc_pc),
      .execute      (execute),
      .opcode       (opcode),
      .addr         (addr),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .busy         (busy),
      .done         (done),
      .last_result  (last_result),
      .issued_count (issued_count),
      .pc_mismatch  (pc_mismatch),
      .timeout_err  (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Host: one-cycle ready responses; a halted host never accepts again.
   always @(posedge clk) begin
      if (!rst_n) begin
         proc_ready  <= 1'b1;
         proc_halt   <= 1'b0;
         proc_result <= '0;
         proc_pc     <= '0;
         h_acc       <= '0;
         h_cnt       <= 0;
      end else begin
         if (start) h_cnt <= 0;
         if (proc_ready && execute && !proc_halt) begin
            proc_ready <= 1'b0;
            h_cnt      <= h_cnt + 1;
            case (opcode)
               OP_ADD:   proc_result <= operand_a + operand_b;
               OP_SUB:   proc_result <= operand_a - operand_b;
               OP_AND:   proc_result <= operand_a & operand_b;
               OP_OR:    proc_result <= operand_a | operand_b;
               OP_LOAD:  begin h_acc <= operand_a; proc_result <= '0; end
               OP_STORE: proc_result <= h_acc;
               OP_JUMP:  proc_result <= '0;
               default:  proc_result <= proc_result;
            endcase
            if (glitch_n != 0 && h_cnt + 1 == glitch_n) proc_pc <= '0;
            else if (opcode == OP_JUMP)                   proc_pc <= addr;
            else if (opcode != OP_HALT && proc_pc != 8'hFF) proc_pc <= proc_pc + 8'd1;
            if (opcode == OP_HALT) proc_halt <= 1'b1;
         end else if (!proc_ready && !execute) begin
            proc_ready <= 1'b1;
         end
      end
   end

   // Each new nonzero issued_count is one capture: compare against the next expectation.
   always @(negedge clk) begin
      if (rst_n && issued_count != prev_cnt && issued_count != '0) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e_mon = sb.pop_front();
            check("last_result", last_result, e_mon.res);
            check("pc_mismatch_cap", pc_mismatch, e_mon.mm);
         end
      end
      prev_cnt <= issued_count;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      m_acc = '0;
      m_res = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_slot(input int idx, input logic [2:0] op, input logic [AW-1:0] ad,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
      p_op[idx] = op; p_addr[idx] = ad; p_a[idx] = a; p_b[idx] = b;
      load_idx  = IW'(idx);
      load_word = {op, ad, a, b};
      load_en   = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic run_prog(input int n, input int gl, input bit exp_tmo, input bit poke);
      int            exec_n;
      bit            mm_final;
      bit            seen;
      logic [DW-1:0] r;
      exec_n   = 0;
      mm_final = 1'b0;
      seen     = 1'b0;
      glitch_n = gl;
      if (!exp_tmo) begin
         for (int i = 0; i < n; i++) begin
            case (p_op[i])
               OP_ADD:   r = p_a[i] + p_b[i];
               OP_SUB:   r = p_a[i] - p_b[i];
               OP_AND:   r = p_a[i] & p_b[i];
               OP_OR:    r = p_a[i] | p_b[i];
               OP_LOAD:  begin m_acc = p_a[i]; r = '0; end
               OP_STORE: r = m_acc;
               OP_JUMP:  r = '0;
               default:  r = m_res;
            endcase
            m_res = r;
            exec_n++;
            mm_final = (gl != 0 && exec_n >= gl);
            sb.push_back('{r, mm_final});
            if (p_op[i] == OP_HALT) break;
         end
      end
      prog_len = CW'(n);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (n > 0) check("execute_rise", execute, 1);
      if (poke) begin
         load_idx  = 4'd1;
         load_word = {OP_HALT, 8'h00, 16'h0000, 16'h0000};
         load_en   = 1'b1;
         @(negedge clk);
         load_en   = 1'b0;
      end
      for (int c = 0; c < 2000 && !seen; c++) begin
         if (done) seen = 1'b1;
         else      @(negedge clk);
      end
      check("done_seen", seen, 1);
      check("issued_count", issued_count, exec_n);
      check("timeout_err", timeout_err, exp_tmo);
      check("pc_mismatch_end", pc_mismatch, mm_final);
      check("busy_at_done", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int seen_done;
      do_reset();
      check("rst_execute", execute, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", issued_count, 0);
      check("rst_result", last_result, 0);
      check("rst_flags", {pc_mismatch, timeout_err}, 0);

      load_slot(0, OP_ADD, 8'h00, 16'h0003, 16'h0004);
      run_prog(1, 0, 1'b0, 1'b0);

      load_slot(0, OP_LOAD, 8'h00, 16'hBEEF, 16'h0000);
      load_slot(1, OP_STORE, 8'h00, 16'h0000, 16'h0000);
      load_slot(2, OP_SUB, 8'h00, 16'h0010, 16'h0001);
      run_prog(3, 0, 1'b0, 1'b0);

      load_slot(0, OP_JUMP, 8'hF0, 16'h0000, 16'h0000);
      load_slot(1, OP_ADD, 8'h00, 16'h1111, 16'h2222);
      load_slot(2, OP_JUMP, 8'hFF, 16'h0000, 16'h0000);
      load_slot(3, OP_ADD, 8'h00, 16'h00F0, 16'h000F);
      run_prog(4, 0, 1'b0, 1'b0);

      load_slot(0, OP_OR, 8'h00, 16'hA000, 16'h000A);
      load_slot(1, OP_HALT, 8'h00, 16'h0000, 16'h0000);
      load_slot(2, OP_AND, 8'h00, 16'hFFFF, 16'h1234);
      load_slot(3, OP_ADD, 8'h00, 16'h0001, 16'h0001);
      run_prog(4, 0, 1'b0, 1'b0);
      run_prog(2, 0, 1'b1, 1'b0);
      do_reset();

      for (int i = 0; i < 4; i++) load_slot(i, OP_ADD, 8'h00, 16'(i + 1), 16'h0100);
      run_prog(4, 3, 1'b0, 1'b1);
      do_reset();

      prog_len = 5'd2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 20 && !execute; c++) @(negedge clk);
      check("abort_exec_high", execute, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_execute", execute, 0);
      check("abort_busy", busy, 0);
      rst_n = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 6; c++) begin
         if (done) seen_done = 1;
         @(negedge clk);
      end
      check("abort_no_done", seen_done, 0);
      m_acc = '0;
      m_res = '0;
      sb.delete();
      run_prog(0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
